// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM arbiter (bram_arbiter, rr_pick).
// The slice macro picks requester i's field out of a packed per-requester bus.
`ifndef BRAM_ARB_SLICE
`define BRAM_ARB_SLICE(bus, idx, width) bus[(idx)*(width) +: (width)]
`endif

package bram_arb_pkg;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    // Index width for n items, never below 1 bit.
    function automatic int req_id_bits(input int n);
        int bits;
        bits = 1;
        while ((1 << bits) < n) bits++;
        return bits;
    endfunction

endpackage

// File: rtl/bram_arbiter_if.sv
// Requester, response and BRAM-side signals of the BRAM arbiter.
// slave is the arbiter's view; master is the clients-plus-BRAM view.
interface bram_arbiter_if #(
    parameter int NUM_REQ       = 4,
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 10
);
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ-1:0]               req_write;
    logic [NUM_REQ-1:0]               req_lock;
    logic [NUM_REQ*RAM_ADDR_BITS-1:0] req_addr;
    logic [NUM_REQ*RAM_WIDTH-1:0]     req_wdata;
    logic [NUM_REQ-1:0]               rsp_valid;
    logic [RAM_WIDTH-1:0]             rsp_data;
    logic                             ram_enable;
    logic                             write_enable;
    logic [RAM_ADDR_BITS-1:0]         ram_address;
    logic [RAM_WIDTH-1:0]             ram_wdata;
    logic [RAM_WIDTH-1:0]             ram_rdata;

    modport slave (
        input  req_valid, req_write, req_lock, req_addr, req_wdata, ram_rdata,
        output req_ready, rsp_valid, rsp_data,
        output ram_enable, write_enable, ram_address, ram_wdata
    );

    modport master (
        output req_valid, req_write, req_lock, req_addr, req_wdata, ram_rdata,
        input  req_ready, rsp_valid, rsp_data,
        input  ram_enable, write_enable, ram_address, ram_wdata
    );
endinterface

// File: rtl/bram_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_pick
    import bram_arb_pkg::*;
#(
    parameter  int N   = 4,
    localparam int IDW = req_id_bits(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx,
    output logic           any
);

    always_comb begin
        int cand;
        cand  = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int off = 1; off <= N; off++) begin
            cand = (int'(last) + off) % N;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one read-first single-port BRAM, with lock bursts.
// Define BRAM_ARB_WRITE_ACK_EN to make writes return a response carrying the old word.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 10,
    parameter int MAX_LOCK      = 16
) (
    input logic           clock,
    input logic           reset_n,
    bram_arbiter_if.slave bus
);

    localparam int IDW  = req_id_bits(NUM_REQ);
    localparam int CNTW = req_id_bits(MAX_LOCK + 1);
`ifdef BRAM_ARB_WRITE_ACK_EN
    localparam bit WRITE_ACK = 1'b1;
`else
    localparam bit WRITE_ACK = 1'b0;
`endif

    lock_state_t          lock_state;
    logic [IDW-1:0]       last, owner, tag;
    logic [IDW-1:0]       pick_idx, grant_idx;
    logic [CNTW-1:0]      lock_cnt;
    logic [NUM_REQ-1:0]   pick_grant, grant, rsp_valid;
    logic                 pick_any, locked, accept, rsp_pending;
    logic                 ram_enable, write_enable;
    logic [RAM_ADDR_BITS-1:0] ram_address;
    logic [RAM_WIDTH-1:0] ram_wdata;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (bus.req_valid),
        .last  (last),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // A lock only holds while its owner keeps asking; an idle owner frees the port this cycle.
    always_comb begin
        locked    = (lock_state == ST_LOCKED) && bus.req_valid[owner];
        grant     = pick_grant;
        grant_idx = pick_idx;
        accept    = pick_any;
        if (locked) begin
            grant        = '0;
            grant[owner] = 1'b1;
            grant_idx    = owner;
            accept       = 1'b1;
        end
    end

    assign bus.req_ready    = grant;
    assign bus.rsp_valid    = rsp_valid;
    assign bus.rsp_data     = bus.ram_rdata;
    assign bus.ram_enable   = ram_enable;
    assign bus.write_enable = write_enable;
    assign bus.ram_address  = ram_address;
    assign bus.ram_wdata    = ram_wdata;

    // Response fires on the edge where the BRAM samples the registered command.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ram_enable   <= 1'b0;
            write_enable <= 1'b0;
            ram_address  <= '0;
            ram_wdata    <= '0;
            last         <= IDW'(NUM_REQ - 1);
            tag          <= '0;
            rsp_pending  <= 1'b0;
            rsp_valid    <= '0;
            lock_state   <= ST_UNLOCKED;
            owner        <= '0;
            lock_cnt     <= '0;
        end else begin
            ram_enable <= accept;
            rsp_valid  <= '0;
            if (ram_enable && rsp_pending)
                rsp_valid[tag] <= 1'b1;

            if (accept) begin
                write_enable <= bus.req_write[grant_idx];
                ram_address  <= `BRAM_ARB_SLICE(bus.req_addr, grant_idx, RAM_ADDR_BITS);
                ram_wdata    <= `BRAM_ARB_SLICE(bus.req_wdata, grant_idx, RAM_WIDTH);
                last         <= grant_idx;
                tag          <= grant_idx;
                rsp_pending  <= WRITE_ACK | ~bus.req_write[grant_idx];
            end

            if (locked) begin
                if (bus.req_lock[owner] && (int'(lock_cnt) + 1 < MAX_LOCK)) begin
                    lock_cnt <= lock_cnt + 1'b1;
                end else begin
                    lock_state <= ST_UNLOCKED;
                    lock_cnt   <= '0;
                end
            end else if (accept && bus.req_lock[grant_idx] && (MAX_LOCK > 1)) begin
                lock_state <= ST_LOCKED;
                owner      <= grant_idx;
                lock_cnt   <= CNTW'(1);
            end else begin
                lock_state <= ST_UNLOCKED;
                lock_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural read-first BRAM.
// Expectations follow BRAM_ARB_WRITE_ACK_EN when it is defined.
module tb_bram_arbiter;

    localparam int NUM_REQ       = 4;
    localparam int RAM_WIDTH     = 8;
    localparam int RAM_ADDR_BITS = 10;
    localparam int MAX_LOCK      = 16;

    logic clock;
    logic reset_n;
    logic preload_en;
    logic [RAM_ADDR_BITS-1:0] preload_addr;
    logic [RAM_WIDTH-1:0]     preload_data;
    logic [RAM_WIDTH-1:0]     mem [0:(1<<RAM_ADDR_BITS)-1];
    int checks;
    int errors;

    bram_arbiter_if #(
        .NUM_REQ(NUM_REQ), .RAM_WIDTH(RAM_WIDTH), .RAM_ADDR_BITS(RAM_ADDR_BITS)
    ) bus ();

    bram_arbiter #(
        .NUM_REQ(NUM_REQ), .RAM_WIDTH(RAM_WIDTH),
        .RAM_ADDR_BITS(RAM_ADDR_BITS), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Read-first single-port BRAM; preload port only used while the arbiter is idle.
    always @(posedge clock) begin
        if (preload_en)
            mem[preload_addr] <= preload_data;
        if (bus.ram_enable) begin
            if (bus.write_enable)
                mem[bus.ram_address] <= bus.ram_wdata;
            bus.ram_rdata <= mem[bus.ram_address];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid,
                                 input logic [NUM_REQ-1:0] write,
                                 input logic [NUM_REQ-1:0] lock);
        bus.req_valid = valid;
        bus.req_write = write;
        bus.req_lock  = lock;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preloadWord(input logic [RAM_ADDR_BITS-1:0] addr,
                               input logic [RAM_WIDTH-1:0] data);
        @(negedge clock);
        preload_addr = addr;
        preload_data = data;
        preload_en   = 1'b1;
        @(negedge clock);
        preload_en   = 1'b0;
    endtask

    task automatic applyReset();
        @(negedge clock);
        applyStimulus('0, '0, '0);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        reset_n       = 1'b0;
        preload_en    = 1'b0;
        preload_addr  = '0;
        preload_data  = '0;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_lock  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        preloadWord(10'h005, 8'h5A);
        for (int i = 0; i < NUM_REQ; i++)
            preloadWord(RAM_ADDR_BITS'(16 + i), RAM_WIDTH'(8'hA0 + i));
        preloadWord(10'h3FF, 8'h11);
        preloadWord(10'h020, 8'h77);

        checkOutput("rst_ram_enable", 32'(bus.ram_enable), 32'h0);
        checkOutput("rst_write_enable", 32'(bus.write_enable), 32'h0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        checkOutput("rst_ram_address", 32'(bus.ram_address), 32'h0);
        checkOutput("rst_ram_wdata", 32'(bus.ram_wdata), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // Single read from requester 0.
        bus.req_addr[0*RAM_ADDR_BITS +: RAM_ADDR_BITS] = 10'h005;
        applyStimulus(4'b0001, 4'b0000, 4'b0000);
        checkOutput("a_ready", 32'(bus.req_ready), 32'h1);
        tick();
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        checkOutput("a_ram_enable", 32'(bus.ram_enable), 32'h1);
        checkOutput("a_ram_address", 32'(bus.ram_address), 32'h005);
        checkOutput("a_write_enable", 32'(bus.write_enable), 32'h0);
        checkOutput("a_rsp_early", 32'(bus.rsp_valid), 32'h0);
        tick();
        checkOutput("a_ram_enable_drop", 32'(bus.ram_enable), 32'h0);
        checkOutput("a_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        checkOutput("a_rsp_data", 32'(bus.rsp_data), 32'h5A);
        tick();
        checkOutput("a_rsp_clear", 32'(bus.rsp_valid), 32'h0);

        // All four read continuously: rotating grants and responses.
        applyReset();
        for (int i = 0; i < NUM_REQ; i++)
            bus.req_addr[i*RAM_ADDR_BITS +: RAM_ADDR_BITS] = RAM_ADDR_BITS'(16 + i);
        applyStimulus(4'b1111, 4'b0000, 4'b0000);
        for (int k = 0; k < 6; k++) begin
            checkOutput("b_ready", 32'(bus.req_ready), 32'(1 << (k % 4)));
            tick();
            checkOutput("b_ram_address", 32'(bus.ram_address), 32'(16 + k % 4));
            if (k >= 1) begin
                checkOutput("b_rsp_valid", 32'(bus.rsp_valid), 32'(1 << ((k - 1) % 4)));
                checkOutput("b_rsp_data", 32'(bus.rsp_data), 32'(8'hA0 + (k - 1) % 4));
            end
        end
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        tick();
        checkOutput("b_rsp_valid_last", 32'(bus.rsp_valid), 32'h2);
        checkOutput("b_rsp_data_last", 32'(bus.rsp_data), 32'hA1);
        tick();
        checkOutput("b_rsp_clear", 32'(bus.rsp_valid), 32'h0);

        // Requester 2 writes 0xC3 to 0x3FF, then requester 1 reads it back.
        bus.req_addr[2*RAM_ADDR_BITS +: RAM_ADDR_BITS] = 10'h3FF;
        bus.req_wdata[2*RAM_WIDTH +: RAM_WIDTH] = 8'hC3;
        applyStimulus(4'b0100, 4'b0100, 4'b0000);
        checkOutput("c_wr_ready", 32'(bus.req_ready), 32'h4);
        tick();
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        checkOutput("c_write_enable", 32'(bus.write_enable), 32'h1);
        checkOutput("c_ram_address", 32'(bus.ram_address), 32'h3FF);
        checkOutput("c_ram_wdata", 32'(bus.ram_wdata), 32'hC3);
        tick();
`ifdef BRAM_ARB_WRITE_ACK_EN
        checkOutput("c_wr_ack_valid", 32'(bus.rsp_valid), 32'h4);
        checkOutput("c_wr_ack_data", 32'(bus.rsp_data), 32'h11);
`else
        checkOutput("c_no_wr_rsp", 32'(bus.rsp_valid), 32'h0);
`endif
        bus.req_addr[1*RAM_ADDR_BITS +: RAM_ADDR_BITS] = 10'h3FF;
        applyStimulus(4'b0010, 4'b0000, 4'b0000);
        checkOutput("c_rd_ready", 32'(bus.req_ready), 32'h2);
        tick();
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        tick();
        checkOutput("c_rd_valid", 32'(bus.rsp_valid), 32'h2);
        checkOutput("c_rd_data", 32'(bus.rsp_data), 32'hC3);
        tick();

        // Requester 1 locks against a continuously valid requester 3.
        applyReset();
        bus.req_addr[1*RAM_ADDR_BITS +: RAM_ADDR_BITS] = 10'h020;
        bus.req_addr[3*RAM_ADDR_BITS +: RAM_ADDR_BITS] = 10'h030;
        applyStimulus(4'b1010, 4'b0000, 4'b0010);
        for (int k = 0; k < MAX_LOCK; k++) begin
            checkOutput("d_lock_ready", 32'(bus.req_ready), 32'h2);
            tick();
        end
        checkOutput("d_handoff_ready", 32'(bus.req_ready), 32'h8);
        tick();
        checkOutput("d_relock_ready", 32'(bus.req_ready), 32'h2);
        tick();
        applyStimulus(4'b1000, 4'b0000, 4'b0000);
        checkOutput("d_owner_idle_release", 32'(bus.req_ready), 32'h8);
        tick();
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        tick();
        tick();

        // Reset lands between a locked read's accept and its response.
        applyReset();
        bus.req_addr[0*RAM_ADDR_BITS +: RAM_ADDR_BITS] = 10'h005;
        applyStimulus(4'b0001, 4'b0000, 4'b0001);
        checkOutput("e_ready", 32'(bus.req_ready), 32'h1);
        tick();
        #2;
        reset_n = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        checkOutput("e_ram_enable_in_reset", 32'(bus.ram_enable), 32'h0);
        checkOutput("e_rsp_in_reset", 32'(bus.rsp_valid), 32'h0);
        tick();
        checkOutput("e_rsp_dropped", 32'(bus.rsp_valid), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(4'b0011, 4'b0000, 4'b0000);
        checkOutput("e_first_grant", 32'(bus.req_ready), 32'h1);
        tick();
        checkOutput("e_lock_cleared", 32'(bus.req_ready), 32'h2);
        checkOutput("e_no_stale_rsp", 32'(bus.rsp_valid), 32'h0);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
